// File: rtl/axi_sram_slave_pkg.sv
// axi_sram_slave_pkg: shared constants and types for the AXI3 SRAM slave.
//   RESP_*     : B/R response codes
//   BURST_*    : AxBURST encodings (WRAP is served as INCR)
//   rd_state_t : read channel FSM states
//   wr_state_t : write channel FSM states
//   next_addr  : per-beat address step for FIXED / INCR bursts
package axi_sram_slave_pkg;

    localparam int ID_W  = 4;
    localparam int LEN_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  wr_state_t;

    // WRAP has no wrap boundary here; it walks like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [1:0]  burst,
                                              input logic [2:0]  size);
        if (burst == BURST_FIXED)
            return addr;
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI3 AR/R/AW/W/B channel bundle.
//   master modport : drives AR/AW/W valid+payload, rready, bready
//   slave  modport : drives arready, R channel, awready, wready, B channel
interface axi_sram_slave_if;
    import axi_sram_slave_pkg::*;

    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arvalid;
    logic             arready;

    logic [ID_W-1:0]  rid;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    logic [ID_W-1:0]  awid;
    logic [31:0]      awaddr;
    logic [LEN_W-1:0] awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;
    logic             awvalid;
    logic             awready;

    logic [ID_W-1:0]  wid;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;

    logic [ID_W-1:0]  bid;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );

endinterface

// File: rtl/axi_sram_slave_mem.sv
// axi_sram_mem: 2^ADDR_W x 32-bit RAM, contents not reset.
//   raddr/rdata        : asynchronous read port
//   we/waddr/wdata/wstrb : synchronous write port, one enable per byte lane
// A same-cycle read of the word being written sees the old value.
module axi_sram_mem #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb
);

    logic [31:0] mem [2**ADDR_W];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave memory model, main-memory responder for the CPU bus.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : axi_sram_slave_if.slave (AR/R/AW/W/B channels)
// Read and write channels run independent FSMs with no ordering between them.
// Optional macro AXI_SLV_RD_DELAY_EN inserts RD_DELAY idle cycles (R_WAIT)
// between the AR handshake and the first R beat; RD_DELAY must be < 256.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int RD_DELAY = 2
) (
    input  logic             clk,
    input  logic             resetn,
    axi_sram_slave_if.slave  bus
);

    // ---------------- read channel ----------------
    rd_state_t        rd_state;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_len, r_cnt;
    logic [2:0]       r_size;
    logic [1:0]       r_burst;
    logic [ID_W-1:0]  rid_q;
    logic             arready_q, rvalid_q;
`ifdef AXI_SLV_RD_DELAY_EN
    logic [7:0]       dly_cnt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state  <= R_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            rid_q     <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
`ifdef AXI_SLV_RD_DELAY_EN
            dly_cnt   <= '0;
`endif
        end else begin
            case (rd_state)
                R_IDLE: if (bus.arvalid) begin
                    r_addr    <= bus.araddr;
                    r_len     <= bus.arlen;
                    r_size    <= bus.arsize;
                    r_burst   <= bus.arburst;
                    rid_q     <= bus.arid;
                    r_cnt     <= '0;
                    arready_q <= 1'b0;
`ifdef AXI_SLV_RD_DELAY_EN
                    dly_cnt   <= '0;
                    if (RD_DELAY == 0) begin
                        rd_state <= R_BURST;
                        rvalid_q <= 1'b1;
                    end else begin
                        rd_state <= R_WAIT;
                    end
`else
                    rd_state  <= R_BURST;
                    rvalid_q  <= 1'b1;
`endif
                end
`ifdef AXI_SLV_RD_DELAY_EN
                R_WAIT: begin
                    if (dly_cnt == 8'(RD_DELAY - 1)) begin
                        rd_state <= R_BURST;
                        rvalid_q <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
`endif
                R_BURST: if (bus.rready) begin
                    if (r_cnt == r_len) begin
                        // AR reopens the cycle after the last beat: one bubble.
                        rd_state  <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= next_addr(r_addr, r_burst, r_size);
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rid     = rid_q;
    assign bus.rresp   = RESP_OKAY;
    assign bus.rlast   = (rd_state == R_BURST) && (r_cnt == r_len);

    // ---------------- write channel ----------------
    wr_state_t        wr_state;
    logic [31:0]      w_addr;
    logic [LEN_W-1:0] w_len, w_cnt;
    logic [2:0]       w_size;
    logic [1:0]       w_burst;
    logic [ID_W-1:0]  bid_q;
    logic [1:0]       bresp_q;
    logic             awready_q, wready_q, bvalid_q;
    logic             w_err;
    logic             beat_err;
    logic             w_fire;

    assign w_fire   = (wr_state == W_DATA) && bus.wvalid;
    // wlast must appear exactly on the beat where the count reaches awlen.
    assign beat_err = w_err | (bus.wlast != (w_cnt == w_len));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state  <= W_IDLE;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_err     <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (bus.awvalid) begin
                    w_addr    <= bus.awaddr;
                    w_len     <= bus.awlen;
                    w_size    <= bus.awsize;
                    w_burst   <= bus.awburst;
                    bid_q     <= bus.awid;
                    w_cnt     <= '0;
                    w_err     <= 1'b0;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    wr_state  <= W_DATA;
                end
                W_DATA: if (bus.wvalid) begin
                    if (w_cnt == w_len) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= beat_err ? RESP_SLVERR : RESP_OKAY;
                        wr_state <= W_RESP;
                    end else begin
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= next_addr(w_addr, w_burst, w_size);
                        w_err  <= beat_err;
                    end
                end
                W_RESP: if (bus.bready) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wr_state  <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

    // ---------------- storage ----------------
    // Upper address bits are dropped, so addresses past the depth alias.
    axi_sram_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .raddr (r_addr[ADDR_W+1:2]),
        .rdata (bus.rdata),
        .we    (w_fire),
        .waddr (w_addr[ADDR_W+1:2]),
        .wdata (bus.wdata),
        .wstrb (bus.wstrb)
    );

    // wid carries no meaning for this slave.
    logic unused_wid;
    assign unused_wid = ^bus.wid;
`ifndef AXI_SLV_RD_DELAY_EN
    logic unused_rd_delay;
    assign unused_rd_delay = (RD_DELAY != 0);
`endif

endmodule
